sdrc_bank_arb: RTL and testbench

SDRC_BANK_ARB -- requirements
Module: sdrc_bank_arb

---
 rtl/sdrc_bank_arb_pkg.sv | 23 ++
 rtl/sdrc_rr_pick4.sv | 27 ++
 rtl/sdrc_bank_arb.sv | 142 ++++++++++++++
 tb/tb_sdrc_bank_arb.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sdrc_bank_arb_pkg.sv
// Shared SDRAM-controller definitions: command opcodes, ID width, arbiter
// state encoding and a command classification helper.
package sdrc_bank_arb_pkg;

  localparam int SDR_REQ_ID_W = 4;
  localparam int ADDR_W       = 12;
  localparam int NUM_BANKS    = 4;

  localparam logic [1:0] OP_PRE = 2'd0;
  localparam logic [1:0] OP_ACT = 2'd1;
  localparam logic [1:0] OP_RD  = 2'd2;
  localparam logic [1:0] OP_WR  = 2'd3;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_t;

  function automatic logic is_data_cmd(input logic [1:0] cmd);
    return (cmd == OP_RD) || (cmd == OP_WR);
  endfunction

endpackage

// File: rtl/sdrc_rr_pick4.sv
// 4-way rotating-priority picker: first requester at or above ptr_i, wrapping 3->0.
module sdrc_rr_pick4 (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic       vld_o,
  output logic [1:0] idx_o
);

  logic [1:0] cand_s;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    vld_o  = 1'b0;
    idx_o  = ptr_i;
    cand_s = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      cand_s = ptr_i + 2'(i);
      if (req_i[cand_s]) begin
        vld_o = 1'b1;
        idx_o = cand_s;
      end else begin
        vld_o = vld_o;
      end
    end
  end

endmodule

// File: rtl/sdrc_bank_arb.sv
// Four-bank command arbiter: urgent (aged) > data > row classes, round-robin
// inside each class, one grant held until acked, abandoned or refreshed.
module sdrc_bank_arb #(
  parameter int APP_RW       = 9,
  parameter int SDR_REQ_ID_W = sdrc_bank_arb_pkg::SDR_REQ_ID_W,
  parameter int AGE_MAX      = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [3:0]                bk_req,
  input  logic [7:0]                bk_cmd,
  input  logic [47:0]               bk_addr,
  input  logic [4*SDR_REQ_ID_W-1:0] bk_id,
  input  logic [4*APP_RW-1:0]       bk_len,
  input  logic [3:0]                bk_start,
  input  logic [3:0]                bk_last,
  input  logic [3:0]                bk_wrap,
  output logic [3:0]                bk_ack,
  output logic                      b2x_req,
  output logic [1:0]                b2x_ba,
  output logic [1:0]                b2x_cmd,
  output logic [11:0]               b2x_addr,
  output logic [SDR_REQ_ID_W-1:0]   b2x_id,
  output logic [APP_RW-1:0]         b2x_len,
  output logic                      b2x_start,
  output logic                      b2x_last,
  output logic                      b2x_wrap,
  input  logic                      x2b_ack,
  input  logic                      x2b_refresh
);
  import sdrc_bank_arb_pkg::*;

  localparam logic [3:0] AGE_MAX_C = 4'(AGE_MAX);

  arb_state_t state_q;
  logic [1:0] gnt_q;
  logic [1:0] rr_q;
  logic [3:0] cnt_q [NUM_BANKS];
  logic [3:0] cnt_d [NUM_BANKS];

  logic [3:0] urg_req_s, data_req_s, row_req_s;
  logic       urg_vld_s, data_vld_s, row_vld_s, any_s;
  logic [1:0] urg_idx_s, data_idx_s, row_idx_s, win_s;
  logic       hold_s, ack_s;

  // Split live requests into the three priority classes.
  always_comb begin
    for (int n = 0; n < NUM_BANKS; n++) begin
      urg_req_s[n]  = bk_req[n] && (cnt_q[n] == AGE_MAX_C);
      data_req_s[n] = bk_req[n] && is_data_cmd(bk_cmd[2*n +: 2]);
      row_req_s[n]  = bk_req[n] && !is_data_cmd(bk_cmd[2*n +: 2]);
    end
  end

  sdrc_rr_pick4 u_pick_urg  (.req_i(urg_req_s),  .ptr_i(rr_q), .vld_o(urg_vld_s),  .idx_o(urg_idx_s));
  sdrc_rr_pick4 u_pick_data (.req_i(data_req_s), .ptr_i(rr_q), .vld_o(data_vld_s), .idx_o(data_idx_s));
  sdrc_rr_pick4 u_pick_row  (.req_i(row_req_s),  .ptr_i(rr_q), .vld_o(row_vld_s),  .idx_o(row_idx_s));

  assign any_s  = urg_vld_s | data_vld_s | row_vld_s;
  assign win_s  = urg_vld_s ? urg_idx_s : (data_vld_s ? data_idx_s : row_idx_s);
  assign hold_s = (state_q == ARB_HOLD);
  // Refresh overrides a same-cycle ack; the grant is dropped instead.
  assign ack_s  = b2x_req && x2b_ack && !x2b_refresh;

  // Granted bank fields pass straight through while holding; zero otherwise.
  always_comb begin
    b2x_req   = 1'b0;
    b2x_ba    = 2'd0;
    b2x_cmd   = 2'd0;
    b2x_addr  = 12'd0;
    b2x_id    = '0;
    b2x_len   = '0;
    b2x_start = 1'b0;
    b2x_last  = 1'b0;
    b2x_wrap  = 1'b0;
    bk_ack    = 4'd0;
    if (hold_s) begin
      b2x_req   = bk_req[gnt_q];
      b2x_ba    = gnt_q;
      b2x_cmd   = bk_cmd[gnt_q*2 +: 2];
      b2x_addr  = bk_addr[gnt_q*ADDR_W +: ADDR_W];
      b2x_id    = bk_id[gnt_q*SDR_REQ_ID_W +: SDR_REQ_ID_W];
      b2x_len   = bk_len[gnt_q*APP_RW +: APP_RW];
      b2x_start = bk_start[gnt_q];
      b2x_last  = bk_last[gnt_q];
      b2x_wrap  = bk_wrap[gnt_q];
      bk_ack    = ack_s ? (4'b0001 << gnt_q) : 4'd0;
    end else begin
      bk_ack    = 4'd0;
    end
  end

  // Per-bank wait age: saturating count while waiting, cleared on ack or idle.
  always_comb begin
    for (int n = 0; n < NUM_BANKS; n++) begin
      if (!bk_req[n] || bk_ack[n]) begin
        cnt_d[n] = 4'd0;
      end else if (cnt_q[n] != AGE_MAX_C) begin
        cnt_d[n] = cnt_q[n] + 4'd1;
      end else begin
        cnt_d[n] = cnt_q[n];
      end
    end
  end

  // Wait counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < NUM_BANKS; n++) cnt_q[n] <= 4'd0;
    end else begin
      for (int n = 0; n < NUM_BANKS; n++) cnt_q[n] <= cnt_d[n];
    end
  end

  // Grant FSM with round-robin pointer advanced only on an accepted command.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ARB_IDLE;
      gnt_q   <= 2'd0;
      rr_q    <= 2'd0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (any_s && !x2b_refresh) begin
            gnt_q   <= win_s;
            state_q <= ARB_HOLD;
          end
        end
        ARB_HOLD: begin
          if (x2b_refresh || !bk_req[gnt_q]) begin
            state_q <= ARB_IDLE;
          end else if (x2b_ack) begin
            state_q <= ARB_IDLE;
            rr_q    <= gnt_q + 2'd1;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdrc_bank_arb.sv
// Directed bench for sdrc_bank_arb: expected grant banks are queued by the
// stimulus and a negedge monitor checks every bk_ack pulse against the queue.
module tb_sdrc_bank_arb;
  import sdrc_bank_arb_pkg::*;

  localparam int APP_RW = 9;
  localparam int IDW    = 4;

  logic                clk = 1'b0;
  logic                reset_n = 1'b1;
  logic [3:0]          bk_req = 4'd0;
  logic [7:0]          bk_cmd = 8'd0;
  logic [47:0]         bk_addr = 48'd0;
  logic [4*IDW-1:0]    bk_id = 16'hA5C3;
  logic [4*APP_RW-1:0] bk_len = 36'd0;
  logic [3:0]          bk_start = 4'b0001;
  logic [3:0]          bk_last = 4'b0000;
  logic [3:0]          bk_wrap = 4'b0001;
  logic [3:0]          bk_ack;
  logic                b2x_req;
  logic [1:0]          b2x_ba;
  logic [1:0]          b2x_cmd;
  logic [11:0]         b2x_addr;
  logic [IDW-1:0]      b2x_id;
  logic [APP_RW-1:0]   b2x_len;
  logic                b2x_start, b2x_last, b2x_wrap;
  logic                x2b_ack = 1'b0;
  logic                x2b_refresh = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [1:0] exp_q [$];

  sdrc_bank_arb #(.APP_RW(APP_RW), .SDR_REQ_ID_W(IDW), .AGE_MAX(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .bk_req(bk_req), .bk_cmd(bk_cmd), .bk_addr(bk_addr), .bk_id(bk_id), .bk_len(bk_len),
    .bk_start(bk_start), .bk_last(bk_last), .bk_wrap(bk_wrap), .bk_ack(bk_ack),
    .b2x_req(b2x_req), .b2x_ba(b2x_ba), .b2x_cmd(b2x_cmd), .b2x_addr(b2x_addr),
    .b2x_id(b2x_id), .b2x_len(b2x_len), .b2x_start(b2x_start), .b2x_last(b2x_last),
    .b2x_wrap(b2x_wrap), .x2b_ack(x2b_ack), .x2b_refresh(x2b_refresh)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bk_req = 4'd0; x2b_ack = 1'b0; x2b_refresh = 1'b0;
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic wait_empty(input int maxc);
    int n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout actual=%0d_pending required=0_pending", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: every ack pulse must match the oldest expected bank.
  always @(negedge clk) begin
    if (reset_n && bk_ack != 4'd0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", {28'd0, bk_ack}, 32'd0);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        chk("ack_bank", {26'd0, bk_ack, b2x_ba}, {26'd0, 4'b0001 << e, e});
      end
    end
  end

  initial begin
    #2 reset_n = 1'b0;
    #1;
    chk("rst_b2x_req", {31'd0, b2x_req}, 32'd0);
    chk("rst_bk_ack", {28'd0, bk_ack}, 32'd0);
    chk("rst_state", {31'd0, dut.state_q}, {31'd0, ARB_IDLE});
    chk("rst_rr", {30'd0, dut.rr_q}, 32'd0);
    step();
    step();
    reset_n = 1'b1;

    // Single ACT on bank 0: grant latency, live field mux, same-cycle ack.
    bk_req = 4'b0001; bk_cmd = {6'd0, OP_ACT}; bk_addr = {36'd0, 12'h123};
    bk_len = {27'd0, 9'h1F0};
    #1 chk("idle_b2x_req", {31'd0, b2x_req}, 32'd0);
    step();
    chk("t1_req", {31'd0, b2x_req}, 32'd1);
    chk("t1_ba", {30'd0, b2x_ba}, 32'd0);
    chk("t1_cmd", {30'd0, b2x_cmd}, {30'd0, OP_ACT});
    chk("t1_fields", {b2x_addr, b2x_id, b2x_len, b2x_start, b2x_last, b2x_wrap},
        {12'h123, 4'h3, 9'h1F0, 1'b1, 1'b0, 1'b1});
    bk_addr = {36'd0, 12'h456};
    #1 chk("t1_live_addr", {20'd0, b2x_addr}, 32'h456);
    exp_q.push_back(2'd0);
    x2b_ack = 1'b1;
    #1 chk("t1_ack_comb", {28'd0, bk_ack}, 32'd1);
    step();
    chk("t1_rr", {30'd0, dut.rr_q}, 32'd1);
    chk("t1_idle", {31'd0, dut.state_q}, {31'd0, ARB_IDLE});
    bk_req = 4'd0; x2b_ack = 1'b0;
    step();

    // All banks RD with continuous ack: plain round-robin 0,1,2,3,0.
    do_reset();
    bk_cmd = 8'hAA; bk_req = 4'hF; x2b_ack = 1'b1;
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    exp_q.push_back(2'd3); exp_q.push_back(2'd0);
    wait_empty(40);
    bk_req = 4'd0; x2b_ack = 1'b0;
    chk("t2_rr", {30'd0, dut.rr_q}, 32'd1);
    step();

    // rr_ptr=1: bank 1 PRE vs bank 2 WR -> data class wins.
    bk_cmd = 8'h30; bk_req = 4'b0110; x2b_ack = 1'b1;
    exp_q.push_back(2'd2);
    wait_empty(20);
    bk_req = 4'd0; x2b_ack = 1'b0;
    chk("t3_rr", {30'd0, dut.rr_q}, 32'd3);
    step();

    // Bank 3 ACT starved by RD on 0..2 until its age saturates.
    do_reset();
    bk_cmd = 8'h6A; bk_req = 4'hF; x2b_ack = 1'b1;
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    exp_q.push_back(2'd0); exp_q.push_back(2'd3);
    wait_empty(60);
    chk("t4_cnt3_cleared", {28'd0, dut.cnt_q[3]}, 32'd0);
    bk_req = 4'd0; x2b_ack = 1'b0;
    step();

    // Refresh together with ack in HOLD: grant dropped, rr kept, IDLE blocked.
    bk_cmd = 8'h20; bk_req = 4'b0100;
    step();
    chk("t5_hold_ba", {29'd0, b2x_req, b2x_ba}, 32'h6);
    x2b_refresh = 1'b1; x2b_ack = 1'b1;
    #1 chk("t5_no_ack", {28'd0, bk_ack}, 32'd0);
    step();
    chk("t5_idle_rr", {29'd0, dut.state_q, dut.rr_q}, {29'd0, ARB_IDLE, 2'd0});
    chk("t5_b2x_req", {31'd0, b2x_req}, 32'd0);
    step();
    chk("t5_refresh_blocks", {31'd0, dut.state_q}, {31'd0, ARB_IDLE});
    x2b_refresh = 1'b0; x2b_ack = 1'b0;
    step();
    chk("t5_regrant", {31'd0, dut.state_q}, {31'd0, ARB_HOLD});
    bk_req = 4'd0;
    #1 chk("t5_drop_live", {31'd0, b2x_req}, 32'd0);
    step();
    chk("t5_abandon", {29'd0, dut.state_q, dut.rr_q}, {29'd0, ARB_IDLE, 2'd0});

    // Request drop in HOLD, then reset asserted mid-HOLD.
    bk_cmd = 8'h08; bk_req = 4'b0010;
    step();
    chk("t6_ba", {30'd0, b2x_ba}, 32'd1);
    exp_q.push_back(2'd1);
    x2b_ack = 1'b1;
    step();
    x2b_ack = 1'b0;
    chk("t6_rr", {30'd0, dut.rr_q}, 32'd2);
    step();
    bk_req = 4'd0;
    #1 chk("t6_drop_req", {31'd0, b2x_req}, 32'd0);
    step();
    chk("t6_abandon", {31'd0, dut.state_q}, {31'd0, ARB_IDLE});
    bk_req = 4'b0010;
    step();
    chk("t6_hold_again", {31'd0, b2x_req}, 32'd1);
    reset_n = 1'b0; x2b_ack = 1'b1;
    #1;
    chk("t6_rst_req", {31'd0, b2x_req}, 32'd0);
    chk("t6_rst_ack", {28'd0, bk_ack}, 32'd0);
    chk("t6_rst_cnt", {16'd0, dut.cnt_q[0], dut.cnt_q[1], dut.cnt_q[2], dut.cnt_q[3]}, 32'd0);
    chk("t6_rst_rr", {30'd0, dut.rr_q}, 32'd0);
    step();
    bk_cmd = 8'h88; bk_req = 4'b1010;
    reset_n = 1'b1;
    exp_q.push_back(2'd1);
    wait_empty(20);
    bk_req = 4'd0; x2b_ack = 1'b0;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
